return_stack: RTL and testbench

Hardware subroutine return-address stack for the Gumnut core, sitting directly upstream of the next-PC selector. On a `jsb` it pushes the return address (PC+1). On a `ret` it pops, and its top-of-stack output is the `stackaddr` operand the next-PC logic selects in that same cycle. It is a parameterised circular LIFO with occupancy flags and sticky overflow/underflow error bits for debug.

---
 rtl/gumnut_pkg.sv | 16 +
 rtl/return_stack.sv | 108 ++++++++++
 tb/tb_return_stack.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gumnut_pkg.sv
// Shared Gumnut core definitions: PC width, PC type and the PC-operation
// encodings that control hands to the next-PC selector.
package gumnut_pkg;

    localparam int PC_W = 12;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        PC_OP_JUMP   = 2'b00,
        PC_OP_BRANCH = 2'b01,
        PC_OP_RETURN = 2'b10,
        PC_OP_RETI   = 2'b11
    } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of subroutine return addresses; top_o feeds the next-PC
// stackaddr operand and is valid in the same cycle a ret pops it.
module return_stack
    import gumnut_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = PC_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [AW-1:0]              push_addr_i,
    input  logic                       clr_err_i,
    output logic [AW-1:0]              top_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_prev;
    logic [CW-1:0]  count;
    logic           ovf;
    logic           unf;
    logic           is_empty;
    logic           is_full;
    logic           wr_en;
    logic [SPW-1:0] wr_idx;

    assign sp_prev  = sp - SPW'(1);
    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);

    assign top_o       = is_empty ? '0 : mem[sp_prev];
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign count_o     = count;
    assign overflow_o  = ovf;
    assign underflow_o = unf;

    // Push+pop on a non-empty stack rewrites the top in place; every other push
    // lands in the next free slot (overwriting the oldest entry when full).
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sp;
        if (push_i && !rst_i) begin
            wr_en  = 1'b1;
            wr_idx = (pop_i && !is_empty) ? sp_prev : sp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= push_addr_i;
        end
    end

    // Error sets are written after the clear so a new event wins over clr_err_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (clr_err_i) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            case ({push_i, pop_i})
                2'b10: begin
                    sp <= sp + SPW'(1);
                    if (is_full) begin
                        ovf <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf <= 1'b1;
                    end else begin
                        sp    <= sp_prev;
                        count <= count - CW'(1);
                    end
                end
                2'b11: begin
                    if (is_empty) begin
                        sp    <= sp + SPW'(1);
                        count <= CW'(1);
                        unf   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: a table of vectors whose expected
// post-edge outputs travel through a scoreboard queue, plus reset sequences.
module tb_return_stack;

    typedef struct {
        logic        rst;
        logic        push;
        logic        pop;
        logic        clr;
        logic [11:0] addr;
        logic [11:0] pre_top;
        logic [11:0] top;
        logic [3:0]  count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] addr = '0;
    logic [11:0] top;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        ovf;
    logic        unf;

    int   compared = 0;
    int   mismatched = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    return_stack #(.DEPTH(8), .AW(12)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_addr_i (addr),
        .clr_err_i   (clr),
        .top_o       (top),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic c,
                                input logic [11:0] a, input logic [11:0] pt, input logic [11:0] t,
                                input logic [3:0] n, input logic o, input logic u);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.clr = c; v.addr = a;
        v.pre_top = pt; v.top = t; v.count = n;
        v.empty = (n == 4'd0); v.full = (n == 4'd8);
        v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        checkValue("top", 32'(top), 32'(e.top));
        checkValue("count", 32'(count), 32'(e.count));
        checkValue("empty", 32'(empty), 32'(e.empty));
        checkValue("full", 32'(full), 32'(e.full));
        checkValue("overflow", 32'(ovf), 32'(e.ovf));
        checkValue("underflow", 32'(unf), 32'(e.unf));
    endtask

    // The pop-cycle top is checked before the edge: next-PC samples it there.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst  = v.rst;
        push = v.push;
        pop  = v.pop;
        clr  = v.clr;
        addr = v.addr;
        exp_q.push_back(v);
        #1;
        if (v.pop && !v.rst) begin
            checkValue("pop_cycle_top", 32'(top), 32'(v.pre_top));
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        // reset held over two edges, then checked while still asserted
        applyStimulus(mk(1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));
        applyStimulus(mk(1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));
        @(negedge clk);
        checkValue("reset_top", 32'(top), 32'h0);
        checkValue("reset_empty", 32'(empty), 32'h1);
        checkValue("reset_count", 32'(count), 32'h0);

        // idle after reset
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));
        // three pushes, three pops
        vecs.push_back(mk(0, 1, 0, 0, 12'h101, 12'h000, 12'h101, 4'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h202, 12'h000, 12'h202, 4'd2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h303, 12'h000, 12'h303, 4'd3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h303, 12'h202, 4'd2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h202, 12'h101, 4'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h101, 12'h000, 4'd0, 0, 0));
        // fill to DEPTH, then one more push overwrites the oldest entry
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 0, 0, 12'h010 + 12'(i), 12'h000, 12'h010 + 12'(i), 4'(i + 1), 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h018, 12'h000, 12'h018, 4'd8, 1, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h018 - 12'(i), 12'h017 - 12'(i), 4'(7 - i), 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h011, 12'h000, 4'd0, 1, 0));
        // clear overflow, then underflow and set-beats-clear
        vecs.push_back(mk(0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h000, 12'h000, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 12'h000, 12'h000, 12'h000, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));
        // replace-top with push+pop
        vecs.push_back(mk(0, 1, 0, 0, 12'h055, 12'h000, 12'h055, 4'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h0AA, 12'h000, 12'h0AA, 4'd2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 12'h0BB, 12'h0AA, 12'h0BB, 4'd2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h0BB, 12'h055, 4'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 12'h000, 12'h055, 12'h000, 4'd0, 0, 0));
        // push+pop on empty behaves as a push and flags underflow
        vecs.push_back(mk(0, 1, 1, 0, 12'h123, 12'h000, 12'h123, 4'd1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 12'h000, 12'h123, 12'h000, 4'd0, 0, 0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // reset with a concurrent push discards the push
        applyStimulus(mk(0, 1, 0, 0, 12'h0E1, 12'h000, 12'h0E1, 4'd1, 0, 0));
        applyStimulus(mk(0, 1, 0, 0, 12'h0E2, 12'h000, 12'h0E2, 4'd2, 0, 0));
        applyStimulus(mk(1, 1, 0, 0, 12'h0E3, 12'h000, 12'h000, 4'd0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 4'd0, 0, 0));

        @(negedge clk);
        checkValue("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
